// File: rtl/mem_walker_pkg.sv
// rtl/mem_walker_pkg.sv - shared defaults and sign-extend helper for the strided address walker
package mem_walker_pkg;

  localparam int DEF_ADDR_WIDTH    = 48;
  localparam int DEF_ADDR_STRIDE_W = 16;
  localparam int DEF_LOOP_ID_W     = 5;
  localparam int DEF_NUM_CH        = 2;
  localparam int SEXT_W            = 64;

  // Replicates bit w-1 of v into every bit above it; w may be 1..64.
  function automatic logic [SEXT_W-1:0] sign_extend(input logic [SEXT_W-1:0] v,
                                                    input logic [6:0] w);
    logic [SEXT_W-1:0] hi;
    hi = ~((SEXT_W'(1) << w) - SEXT_W'(1));
    return v[6'(w - 7'd1)] ? (v | hi) : (v & ~hi);
  endfunction

endpackage

// File: rtl/mem_walker_chan.sv
// rtl/mem_walker_chan.sv - one address channel: stride/snapshot tables, walk register, write pointer
// Circular-buffer wrap is built only with MEM_WALKER_BOUNDS_EN defined.
module mem_walker_chan
  import mem_walker_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int ADDR_STRIDE_W = DEF_ADDR_STRIDE_W,
  parameter int LOOP_ID_W     = DEF_LOOP_ID_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
`ifdef MEM_WALKER_BOUNDS_EN
  input  logic [ADDR_WIDTH-1:0]    addr_limit,
`endif
  input  logic                     loop_init,
  input  logic                     loop_enter,
  input  logic                     loop_exit,
  input  logic [LOOP_ID_W-1:0]     loop_index,
  input  logic                     loop_index_valid,
  input  logic                     loop_ctrl_done,
  input  logic                     cfg_we,
  input  logic [ADDR_STRIDE_W-1:0] cfg_stride,
  output logic [ADDR_WIDTH-1:0]    addr_out,
  output logic                     cfg_ovf
);

  localparam int DEPTH = 1 << LOOP_ID_W;

  logic [ADDR_STRIDE_W-1:0] stride_q [DEPTH];
  logic [ADDR_WIDTH-1:0]    sav_q    [DEPTH];

  logic [ADDR_WIDTH-1:0] walk_q, walk_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LOOP_ID_W:0]    wptr_q, wptr_d;
  logic [LOOP_ID_W-1:0]  wslot;
  logic                  wfull, wr_ok, step_en, enter_en;
  logic [ADDR_WIDTH-1:0] stride_ext, walk_inc;

  // The extra wptr bit marks that the last slot has already been written.
  assign wfull    = wptr_q[LOOP_ID_W];
  assign wslot    = wptr_q[LOOP_ID_W-1:0];
  assign wr_ok    = cfg_we & ~wfull;
  assign cfg_ovf  = cfg_we & wfull;
  assign step_en  = loop_index_valid & ~loop_init;
  assign enter_en = loop_enter & ~loop_init;

  assign stride_ext = ADDR_WIDTH'(sign_extend(SEXT_W'(stride_q[loop_index]), 7'(ADDR_STRIDE_W)));

`ifdef MEM_WALKER_BOUNDS_EN
  logic [ADDR_WIDTH-1:0] lo_q, lim_q, nxt, top;

  assign nxt = walk_q + stride_ext;
  assign top = lo_q + lim_q;

  always_comb begin
    walk_inc = nxt;
    if (nxt >= top) begin
      walk_inc = nxt - lim_q;
    end else if (nxt < lo_q) begin
      walk_inc = nxt + lim_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q  <= '0;
      lim_q <= '0;
    end else if (loop_init) begin
      lo_q  <= base_addr;
      lim_q <= addr_limit;
    end
  end
`else
  assign walk_inc = walk_q + stride_ext;
`endif

  always_comb begin
    walk_d = walk_q;
    addr_d = addr_q;
    wptr_d = wptr_q;
    if (cfg_we) begin
      if (!wfull) begin
        wptr_d = wptr_q + (LOOP_ID_W+1)'(1);
      end
    end else if (loop_ctrl_done) begin
      wptr_d = '0;
    end
    // Restore beats increment; addr still captures the pre-restore walk value.
    if (loop_init) begin
      walk_d = base_addr;
    end else if (loop_exit) begin
      walk_d = sav_q[loop_index];
    end else if (loop_index_valid) begin
      walk_d = walk_inc;
    end
    if (step_en) begin
      addr_d = walk_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      walk_q <= '0;
      addr_q <= '0;
      wptr_q <= '0;
    end else begin
      walk_q <= walk_d;
      addr_q <= addr_d;
      wptr_q <= wptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      stride_q[wslot] <= cfg_stride;
      sav_q[wslot]    <= '0;
    end
    if (enter_en) begin
      sav_q[loop_index] <= walk_q;
    end
  end

  assign addr_out = addr_q;

endmodule

// File: rtl/mem_walker_stride_mc.sv
// rtl/mem_walker_stride_mc.sv - multi-channel strided address walker top: config demux, valid, cfg_err
// Optional circular-buffer wrap and cfg_addr_limit port with MEM_WALKER_BOUNDS_EN defined.
module mem_walker_stride_mc
  import mem_walker_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int ADDR_STRIDE_W = DEF_ADDR_STRIDE_W,
  parameter int LOOP_ID_W     = DEF_LOOP_ID_W,
  parameter int NUM_CH        = DEF_NUM_CH
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]                 base_addr,
`ifdef MEM_WALKER_BOUNDS_EN
  input  logic [NUM_CH*ADDR_WIDTH-1:0]                 cfg_addr_limit,
`endif
  input  logic                                         loop_init,
  input  logic                                         loop_enter,
  input  logic                                         loop_exit,
  input  logic [LOOP_ID_W-1:0]                         loop_index,
  input  logic                                         loop_index_valid,
  input  logic                                         loop_ctrl_done,
  input  logic                                         cfg_addr_stride_v,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_addr_stride_ch,
  input  logic [ADDR_STRIDE_W-1:0]                     cfg_addr_stride,
  output logic [NUM_CH*ADDR_WIDTH-1:0]                 addr_out,
  output logic                                         addr_out_valid,
  output logic                                         cfg_err
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] ch_we, ch_ovf;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_we[c] = cfg_addr_stride_v && (cfg_addr_stride_ch == CH_W'(c));

    mem_walker_chan #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .ADDR_STRIDE_W (ADDR_STRIDE_W),
      .LOOP_ID_W     (LOOP_ID_W)
    ) u_chan (
      .clk              (clk),
      .reset            (reset),
      .base_addr        (base_addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
`ifdef MEM_WALKER_BOUNDS_EN
      .addr_limit       (cfg_addr_limit[c*ADDR_WIDTH +: ADDR_WIDTH]),
`endif
      .loop_init        (loop_init),
      .loop_enter       (loop_enter),
      .loop_exit        (loop_exit),
      .loop_index       (loop_index),
      .loop_index_valid (loop_index_valid),
      .loop_ctrl_done   (loop_ctrl_done),
      .cfg_we           (ch_we[c]),
      .cfg_stride       (cfg_addr_stride),
      .addr_out         (addr_out[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .cfg_ovf          (ch_ovf[c])
    );
  end

  // A dropped write in the same cycle as loop_ctrl_done still flags the error.
  always_comb begin
    valid_d = loop_index_valid & ~loop_init;
    err_d   = err_q;
    if (|ch_ovf) begin
      err_d = 1'b1;
    end else if (loop_ctrl_done) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign addr_out_valid = valid_q;
  assign cfg_err        = err_q;

endmodule

// File: tb/tb_mem_walker_stride_mc.sv
// tb/tb_mem_walker_stride_mc.sv - directed bench with an address-walk model for mem_walker_stride_mc
// Runs the circular-buffer case only with MEM_WALKER_BOUNDS_EN defined.
`timescale 1ns/1ps
module tb_mem_walker_stride_mc;

  localparam int AW = 48;
  localparam int SW = 16;
  localparam int LW = 5;
  localparam int NC = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC*AW-1:0] base_addr;
  logic             loop_init, loop_enter, loop_exit, loop_index_valid, loop_ctrl_done;
  logic [LW-1:0]    loop_index;
  logic             cfg_addr_stride_v;
  logic [0:0]       cfg_addr_stride_ch;
  logic [SW-1:0]    cfg_addr_stride;
  logic [NC*AW-1:0] addr_out;
  logic             addr_out_valid, cfg_err;
`ifdef MEM_WALKER_BOUNDS_EN
  logic [NC*AW-1:0] cfg_addr_limit;
`endif

  mem_walker_stride_mc dut (
    .clk                (clk),
    .reset              (reset),
    .base_addr          (base_addr),
`ifdef MEM_WALKER_BOUNDS_EN
    .cfg_addr_limit     (cfg_addr_limit),
`endif
    .loop_init          (loop_init),
    .loop_enter         (loop_enter),
    .loop_exit          (loop_exit),
    .loop_index         (loop_index),
    .loop_index_valid   (loop_index_valid),
    .loop_ctrl_done     (loop_ctrl_done),
    .cfg_addr_stride_v  (cfg_addr_stride_v),
    .cfg_addr_stride_ch (cfg_addr_stride_ch),
    .cfg_addr_stride    (cfg_addr_stride),
    .addr_out           (addr_out),
    .addr_out_valid     (addr_out_valid),
    .cfg_err            (cfg_err)
  );

  always #5 clk = ~clk;

  // Model state: what each channel must hold according to the walk rules.
  logic [AW-1:0] m_stride [NC][DEPTH];
  bit            m_sk     [NC][DEPTH];
  logic [AW-1:0] m_sav    [NC][DEPTH];
  bit            m_vk     [NC][DEPTH];
  logic [AW-1:0] m_walk [NC];
  bit            m_wk   [NC];
  logic [AW-1:0] m_addr [NC];
  bit            m_ak   [NC];
  logic [AW-1:0] m_base [NC];
  logic [AW-1:0] m_lim  [NC];
  int            m_wptr [NC];
  bit            m_valid, m_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] sx(input logic [SW-1:0] v);
    longint s;
    s = longint'($signed(v));
    return AW'(s);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_walk[c] = '0; m_wk[c] = 1'b1;
      m_addr[c] = '0; m_ak[c] = 1'b1;
      m_base[c] = '0; m_lim[c] = '0;
      m_wptr[c] = 0;
      for (int l = 0; l < DEPTH; l++) begin
        m_sk[c][l] = 1'b0;
        m_vk[c][l] = 1'b0;
      end
    end
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic step(input bit init, input bit enter, input bit ext, input bit iv, input bit done,
                      input int idx, input bit wv, input int wch, input logic [SW-1:0] wval);
    bit            ovf;
    logic [AW-1:0] st_old [NC];
    bit            stk_old [NC];
    logic [AW-1:0] sv_old [NC];
    bit            svk_old [NC];
    logic [AW-1:0] pre, nxt;
    loop_init = init; loop_enter = enter; loop_exit = ext;
    loop_index_valid = iv; loop_ctrl_done = done; loop_index = LW'(idx);
    cfg_addr_stride_v = wv; cfg_addr_stride_ch = 1'(wch); cfg_addr_stride = wval;
    for (int c = 0; c < NC; c++) begin
      st_old[c] = m_stride[c][idx]; stk_old[c] = m_sk[c][idx];
      sv_old[c] = m_sav[c][idx];    svk_old[c] = m_vk[c][idx];
    end
    ovf = 1'b0;
    if (wv) begin
      if (m_wptr[wch] == DEPTH) ovf = 1'b1;
      else begin
        m_stride[wch][m_wptr[wch]] = sx(wval);
        m_sk[wch][m_wptr[wch]] = 1'b1;
        m_sav[wch][m_wptr[wch]] = '0;
        m_vk[wch][m_wptr[wch]] = 1'b1;
        m_wptr[wch]++;
      end
    end
    for (int c = 0; c < NC; c++) if (done && !(wv && wch == c)) m_wptr[c] = 0;
    if (ovf) m_err = 1'b1;
    else if (done) m_err = 1'b0;
    m_valid = iv && !init;
    for (int c = 0; c < NC; c++) begin
      pre = m_walk[c];
      if (init) begin
        m_walk[c] = base_addr[c*AW +: AW];
        m_wk[c]   = 1'b1;
        m_base[c] = base_addr[c*AW +: AW];
`ifdef MEM_WALKER_BOUNDS_EN
        m_lim[c]  = cfg_addr_limit[c*AW +: AW];
`endif
      end else begin
        if (enter) begin
          m_sav[c][idx] = pre;
          m_vk[c][idx]  = m_wk[c];
        end
        if (iv) begin
          m_addr[c] = pre;
          m_ak[c]   = m_wk[c];
        end
        if (ext) begin
          m_walk[c] = sv_old[c];
          m_wk[c]   = svk_old[c];
        end else if (iv) begin
          nxt = pre + st_old[c];
`ifdef MEM_WALKER_BOUNDS_EN
          if (nxt >= m_base[c] + m_lim[c]) nxt = nxt - m_lim[c];
          else if (nxt < m_base[c]) nxt = nxt + m_lim[c];
`endif
          m_walk[c] = nxt;
          m_wk[c]   = m_wk[c] && stk_old[c];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();          step(0, 0, 0, 0, 0, 0, 0, 0, '0);   endtask
  task automatic wr(input int ch, input logic [SW-1:0] v); step(0, 0, 0, 0, 0, 0, 1, ch, v); endtask
  task automatic start();         step(1, 0, 0, 0, 0, 0, 0, 0, '0);   endtask
  task automatic iter(input int l); step(0, 0, 0, 1, 0, l, 0, 0, '0); endtask
  task automatic enter(input int l); step(0, 1, 0, 0, 0, l, 0, 0, '0); endtask
  task automatic leave(input int l); step(0, 0, 1, 0, 0, l, 0, 0, '0); endtask
  task automatic finish_prog();   step(0, 0, 0, 0, 1, 0, 0, 0, '0);   endtask

  task automatic exp_addr(input string name, input int ch, input logic [AW-1:0] v);
    chk(name, addr_out[ch*AW +: AW], v);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("cyc_valid", AW'(addr_out_valid), AW'(m_valid));
      chk("cyc_cfg_err", AW'(cfg_err), AW'(m_err));
      for (int c = 0; c < NC; c++)
        if (m_ak[c]) chk($sformatf("cyc_addr_out%0d", c), addr_out[c*AW +: AW], m_addr[c]);
    end
  end

  logic [AW-1:0] nest_exp [6] = '{48'h1000, 48'h1004, 48'h1008, 48'h1040, 48'h1044, 48'h1048};
  logic [AW-1:0] ch1_exp  [4] = '{48'h20, 48'h18, 48'h10, 48'h08};
  logic [AW-1:0] ch0_exp  [4] = '{48'h1000, 48'h1004, 48'h1008, 48'h100c};
  logic [AW-1:0] wrap_exp [5] = '{48'h100, 48'h110, 48'h120, 48'h100, 48'h110};

  initial begin
    reset = 1'b0;
    base_addr = '0;
`ifdef MEM_WALKER_BOUNDS_EN
    cfg_addr_limit = '0;
`endif
    loop_init = 0; loop_enter = 0; loop_exit = 0; loop_index_valid = 0; loop_ctrl_done = 0;
    loop_index = '0; cfg_addr_stride_v = 0; cfg_addr_stride_ch = '0; cfg_addr_stride = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_addr_out", addr_out[AW-1:0], '0);
    chk("rst_addr_out1", addr_out[2*AW-1:AW], '0);
    chk("rst_valid", AW'(addr_out_valid), '0);
    chk("rst_cfg_err", AW'(cfg_err), '0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // 2x3 nest on ch0: l0 = 64, l1 = 4.
    base_addr = {48'h20, 48'h1000};
    wr(0, 16'd64); wr(0, 16'd4); wr(0, 16'd4);
    wr(1, 16'h0010); wr(1, 16'h0002); wr(1, 16'hfff8);
    start();
    enter(0);
    for (int o = 0; o < 2; o++) begin
      enter(1);
      for (int i = 0; i < 3; i++) begin
        iter(1);
        exp_addr($sformatf("nest_addr%0d", o*3+i), 0, nest_exp[o*3+i]);
        chk("nest_valid", AW'(addr_out_valid), AW'(1));
      end
      leave(1);
      chk("nest_valid_drop", AW'(addr_out_valid), AW'(0));
      iter(0);
    end
    leave(0);

    // Negative stride on ch1 with ch0 walking independently at level 2.
    start();
    for (int i = 0; i < 4; i++) begin
      iter(2);
      exp_addr($sformatf("neg_ch1_%0d", i), 1, ch1_exp[i]);
      exp_addr($sformatf("neg_ch0_%0d", i), 0, ch0_exp[i]);
    end
    idle();
    exp_addr("hold_while_idle", 1, 48'h08);

    // Exit together with an iteration: capture pre-restore, then walk resumes from snapshot.
    start();
    enter(1);
    iter(1); iter(1);
    step(0, 0, 1, 1, 0, 1, 0, 0, '0);
    exp_addr("exit_iv_pre", 0, 48'h1008);
    exp_addr("exit_iv_pre_ch1", 1, 48'h24);
    iter(1);
    exp_addr("exit_iv_restored", 0, 48'h1000);

    // Stride table overflow on ch0.
    finish_prog();
    for (int k = 0; k < 32; k++) wr(0, 16'h0100 + 16'(k));
    chk("ovf_before", AW'(cfg_err), AW'(0));
    wr(0, 16'h7777);
    chk("ovf_after", AW'(cfg_err), AW'(1));
    base_addr = {48'h500, 48'h0};
    start();
    iter(31); iter(31);
    exp_addr("ovf_slot31_kept", 0, 48'h11f);

    // Asynchronous reset between edges mid-walk.
    #2 reset = 1'b1;
    #1;
    chk("midrst_addr_out0", addr_out[AW-1:0], '0);
    chk("midrst_addr_out1", addr_out[2*AW-1:AW], '0);
    chk("midrst_valid", AW'(addr_out_valid), '0);
    chk("midrst_cfg_err", AW'(cfg_err), '0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    wr(0, 16'h0008); wr(1, 16'h0003);
    base_addr = {48'h500, 48'h3000};
    start();
    iter(0);
    exp_addr("restart0", 0, 48'h3000);
    iter(0);
    exp_addr("restart1", 0, 48'h3008);

    // loop_ctrl_done clears cfg_err and the write pointer.
    finish_prog();
    for (int k = 0; k < 33; k++) wr(0, 16'h0200 + 16'(k));
    chk("ovf2_after", AW'(cfg_err), AW'(1));
    finish_prog();
    chk("done_clears_err", AW'(cfg_err), AW'(0));
    wr(0, 16'h0020); wr(1, 16'h0003);
    base_addr = {48'h500, 48'h0};
    start();
    iter(0); iter(0);
    exp_addr("done_wptr_zero", 0, 48'h20);

`ifdef MEM_WALKER_BOUNDS_EN
    finish_prog();
    wr(0, 16'h0010); wr(1, 16'h0001);
    cfg_addr_limit = {48'h100000, 48'h30};
    base_addr = {48'h0, 48'h100};
    start();
    for (int i = 0; i < 5; i++) begin
      iter(0);
      exp_addr($sformatf("wrap%0d", i), 0, wrap_exp[i]);
    end
`endif

    idle();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_walker_stride_mc.md
MEM_WALKER_STRIDE_MC -- requirements
Module: mem_walker_stride_mc

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 48: address width per channel.
REQ-002 SHALL have parameter ADDR_STRIDE_W, default 16: stride width, two's-complement signed.
REQ-003 SHALL have parameter LOOP_ID_W, default 5: loop-level index width; table depth is 2^LOOP_ID_W.
REQ-004 SHALL have parameter NUM_CH, default 2: number of independent address channels.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-007 SHALL have port base_addr, input, NUM_CH*ADDR_WIDTH: per-channel base address; channel c occupies bits [c*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port loop_init, input, 1: start of walk; load the base address.
REQ-009 SHALL have port loop_enter, input, 1: entering the loop level given by loop_index.
REQ-010 SHALL have port loop_exit, input, 1: leaving the loop level given by loop_index.
REQ-011 SHALL have port loop_index, input, LOOP_ID_W: active loop level.
REQ-012 SHALL have port loop_index_valid, input, 1: one iteration of loop level loop_index.
REQ-013 SHALL have port loop_ctrl_done, input, 1: program finished; clear the config write pointers.
REQ-014 SHALL have port cfg_addr_stride_v, input, 1: stride write strobe.
REQ-015 SHALL have port cfg_addr_stride_ch, input, clog2(NUM_CH) (minimum 1): target channel of the stride write.
REQ-016 SHALL have port cfg_addr_stride, input, ADDR_STRIDE_W: stride value.
REQ-017 SHALL have port addr_out, output, NUM_CH*ADDR_WIDTH: registered per-channel address, packed as base_addr.
REQ-018 SHALL have port addr_out_valid, output, 1: addr_out holds a new address this cycle.
REQ-019 SHALL have port cfg_err, output, 1: sticky flag, stride table overflow.

Function
REQ-020 Per channel, SHALL hold: stride table stride[l]; snapshot table sav[l]; walk register walk_q; write pointer wptr. All tables have combinational read.
REQ-021 A stride write SHALL set stride[wptr] = cfg_addr_stride and sav[wptr] = 0 for the channel selected by cfg_addr_stride_ch, then increment that channel's wptr.
REQ-022 When a channel's wptr equals 2^LOOP_ID_W-1 and was already written, a further write to that channel SHALL be dropped and SHALL set cfg_err.
REQ-023 loop_ctrl_done SHALL clear every wptr and cfg_err; a stride write in the same cycle SHALL take precedence for its channel's wptr.
REQ-024 loop_init SHALL set walk_q = base_addr[c] in every channel; it SHALL override loop_enter, loop_exit and loop_index_valid in that cycle.
REQ-025 loop_enter SHALL set sav[loop_index] = walk_q.
REQ-026 loop_index_valid SHALL set addr_out = walk_q and walk_q = walk_q + sign_extend(stride[loop_index]), with addr_out_valid = 1 on the next cycle (latency 1).
REQ-027 loop_exit SHALL set walk_q = sav[loop_index]; when loop_index_valid occurs in the same cycle, the restore SHALL win for walk_q while addr_out still captures the pre-restore walk_q.
REQ-028 When loop_enter and loop_index_valid occur in the same cycle, the snapshot SHALL capture walk_q before the increment.
REQ-029 The resulting addressing SHALL be addr = base + sum over l of i_l*stride_l.
REQ-030 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; no saturation.
REQ-031 addr_out SHALL hold its value while addr_out_valid is low.

Reset
REQ-032 On reset assertion, SHALL asynchronously clear: addr_out = 0, addr_out_valid = 0, cfg_err = 0, walk_q = 0, wptr = 0.
REQ-033 Table contents SHALL be don't-care after reset, and SHALL be valid only after they are written.
REQ-034 Reset mid-walk SHALL abort the walk; the walk resumes only after loop_init.

Configuration
REQ-035 With macro MEM_WALKER_BOUNDS_EN defined, SHALL add input cfg_addr_limit (NUM_CH*ADDR_WIDTH), sampled at loop_init.
REQ-036 With MEM_WALKER_BOUNDS_EN, an increment yielding next >= base+limit SHALL store next-limit, and one yielding next < base SHALL store next+limit (circular buffer; |stride| < limit required).
REQ-037 Without MEM_WALKER_BOUNDS_EN, the port and the wrap logic SHALL be absent and behaviour SHALL follow REQ-030.

Structure
REQ-038 Shared package mem_walker_pkg SHALL hold the default ADDR_WIDTH, ADDR_STRIDE_W, LOOP_ID_W and NUM_CH, and a sign-extend function.
REQ-039 Sub-module mem_walker_chan SHALL implement one channel (tables, walk_q, wptr, wrap logic), instantiated NUM_CH times.
REQ-040 The top level SHALL contain only the config demux, the valid register and cfg_err.

Verification
REQ-041 SHALL cover: ch0 strides {l0 = 64, l1 = 4}, base 0x1000, 2x3 nest -> addr_out sequence 0x1000, 1004, 1008, 1040, 1044, 1048, one valid per iteration, latency 1.
REQ-042 SHALL cover: ch1 stride -8, base 0x20, 4 iterations -> 0x20, 0x18, 0x10, 0x08; ch0 independent in the same run.
REQ-043 SHALL cover: 33 writes to ch0 with LOOP_ID_W = 5 -> cfg_err = 1 after the 33rd write and stride[31] unchanged; loop_ctrl_done -> cfg_err = 0, wptr = 0.
REQ-044 SHALL cover: loop_exit and loop_index_valid in the same cycle -> addr_out = pre-restore value, walk_q = sav value.
REQ-045 SHALL cover: MEM_WALKER_BOUNDS_EN, base 0x100, limit 0x30, stride 0x10, 5 iterations -> 0x100, 110, 120, 100, 110.
REQ-046 SHALL cover: reset asserted between clock edges mid-walk -> outputs 0 immediately; after loop_init the walk restarts at base.
